// File: rtl/ni_class_router.sv
`default_nettype none
// ============================================================================
//  Module   : ni_class_router
//  Brief    : N-input, single-output two-class router stage. Round-robin per
//             class into a priority FIFO and a regular FIFO; priority drains
//             first. Optional macro STARVE_GUARD_EN forces a regular read after
//             MAX_STARVE consecutive priority reads.
//  Revision : 1.0
// ============================================================================

module ni_class_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_wr,
  input  logic [DATA_W-1:0]            i_wdata,
  input  logic                         i_rd,
  output logic [DATA_W-1:0]            o_head,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);
  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = $clog2(DEPTH+1);

  logic [DATA_W-1:0]  r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wptr;
  logic [c_PTR_W-1:0] r_rptr;
  logic [c_CNT_W-1:0] r_count;
  logic               w_wr;
  logic               w_rd;

  assign o_full  = (r_count == c_CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rptr];
  // Full is judged before the same-cycle read, so a full FIFO never takes a write.
  assign w_wr    = i_wr & ~o_full;
  assign w_rd    = i_rd & ~o_empty;

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= i_wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

module ni_class_router #(
  parameter int         NUM_IN     = 3,
  parameter int         DATA_W     = 16,
  parameter int         FIFO_DEPTH = 8,
  parameter logic [2:0] PRIO_HEAD  = 3'b001,
  parameter int         MAX_STARVE = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_IN*DATA_W-1:0]            input_data,
  input  logic [NUM_IN-1:0]                   input_req,
  output logic [NUM_IN-1:0]                   input_bussy,
  output logic [DATA_W-1:0]                   output_data,
  output logic                                output_req,
  input  logic                                output_bussy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     prio_count,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     reg_count
);
  localparam int c_IDX_W = $clog2(NUM_IN);

  logic [NUM_IN-1:0]  w_req_prio;
  logic [NUM_IN-1:0]  w_req_reg;
  logic [NUM_IN-1:0]  w_gnt_prio;
  logic [NUM_IN-1:0]  w_gnt_reg;
  logic [c_IDX_W-1:0] r_rr_prio;
  logic [c_IDX_W-1:0] r_rr_reg;
  logic [c_IDX_W-1:0] w_rr_prio_nxt;
  logic [c_IDX_W-1:0] w_rr_reg_nxt;
  logic [DATA_W-1:0]  w_wdata_prio;
  logic [DATA_W-1:0]  w_wdata_reg;
  logic [DATA_W-1:0]  w_head_prio;
  logic [DATA_W-1:0]  w_head_reg;
  logic               w_full_prio;
  logic               w_full_reg;
  logic               w_empty_prio;
  logic               w_empty_reg;
  logic               w_force_reg;
  logic               w_sel_prio;
  logic               w_pop;
  logic               w_pop_prio;
  logic               w_pop_reg;

  // Grant the requester with the smallest wrapped distance from the pointer.
  function automatic logic [NUM_IN-1:0] rr_pick(input logic [NUM_IN-1:0] req,
                                                input logic [c_IDX_W-1:0] ptr);
    logic [NUM_IN-1:0] gnt;
    int best;
    gnt  = '0;
    best = NUM_IN;
    for (int i = 0; i < NUM_IN; i++) begin
      if (req[i] && (((i + NUM_IN - int'(ptr)) % NUM_IN) < best))
        best = (i + NUM_IN - int'(ptr)) % NUM_IN;
    end
    for (int i = 0; i < NUM_IN; i++) begin
      gnt[i] = req[i] && (((i + NUM_IN - int'(ptr)) % NUM_IN) == best);
    end
    return gnt;
  endfunction

  always_comb begin
    w_req_prio = '0;
    w_req_reg  = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (input_data[i*DATA_W + DATA_W - 1 -: 3] == PRIO_HEAD)
        w_req_prio[i] = rst & input_req[i] & ~w_full_prio;
      else
        w_req_reg[i]  = rst & input_req[i] & ~w_full_reg;
    end
  end

  assign w_gnt_prio  = rr_pick(w_req_prio, r_rr_prio);
  assign w_gnt_reg   = rr_pick(w_req_reg,  r_rr_reg);
  assign input_bussy = input_req & ~(w_gnt_prio | w_gnt_reg);

  always_comb begin
    w_wdata_prio  = '0;
    w_wdata_reg   = '0;
    w_rr_prio_nxt = r_rr_prio;
    w_rr_reg_nxt  = r_rr_reg;
    for (int i = 0; i < NUM_IN; i++) begin
      if (w_gnt_prio[i]) begin
        w_wdata_prio  = input_data[i*DATA_W +: DATA_W];
        w_rr_prio_nxt = c_IDX_W'((i + 1) % NUM_IN);
      end
      if (w_gnt_reg[i]) begin
        w_wdata_reg  = input_data[i*DATA_W +: DATA_W];
        w_rr_reg_nxt = c_IDX_W'((i + 1) % NUM_IN);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rr_prio <= '0;
      r_rr_reg  <= '0;
    end else begin
      r_rr_prio <= w_rr_prio_nxt;
      r_rr_reg  <= w_rr_reg_nxt;
    end
  end

  ni_class_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo_prio (
    .clk     (clk),
    .rst     (rst),
    .i_wr    (|w_gnt_prio),
    .i_wdata (w_wdata_prio),
    .i_rd    (w_pop_prio),
    .o_head  (w_head_prio),
    .o_full  (w_full_prio),
    .o_empty (w_empty_prio),
    .o_count (prio_count)
  );

  ni_class_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo_reg (
    .clk     (clk),
    .rst     (rst),
    .i_wr    (|w_gnt_reg),
    .i_wdata (w_wdata_reg),
    .i_rd    (w_pop_reg),
    .o_head  (w_head_reg),
    .o_full  (w_full_reg),
    .o_empty (w_empty_reg),
    .o_count (reg_count)
  );

`ifdef STARVE_GUARD_EN
  localparam int c_STARVE_W = $clog2(MAX_STARVE + 1);
  logic [c_STARVE_W-1:0] r_starve;

  assign w_force_reg = (r_starve == c_STARVE_W'(MAX_STARVE)) & ~w_empty_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_starve <= '0;
    end else if (w_empty_reg || w_pop_reg) begin
      r_starve <= '0;
    end else if (w_pop_prio) begin
      r_starve <= r_starve + 1'b1;
    end
  end
`else
  assign w_force_reg = 1'b0;
`endif

  // Output is held quiet while reset is asserted so nothing pops mid-reset.
  assign w_sel_prio  = ~w_empty_prio & ~w_force_reg;
  assign output_req  = rst & (w_sel_prio | ~w_empty_reg);
  assign w_pop       = output_req & ~output_bussy;
  assign w_pop_prio  = w_pop & w_sel_prio;
  assign w_pop_reg   = w_pop & ~w_sel_prio;
  assign output_data = !output_req ? '0 : (w_sel_prio ? w_head_prio : w_head_reg);

endmodule
`default_nettype wire

// File: tb/tb_ni_class_router.sv
`default_nettype none
// Randomized scoreboard bench for ni_class_router against a queue-based reference model.
module tb_ni_class_router;
  localparam int         NUM_IN     = 3;
  localparam int         DATA_W     = 16;
  localparam int         DEPTH      = 8;
  localparam int         MAX_STARVE = 4;
  localparam logic [2:0] PRIO       = 3'b001;
  localparam int         CW         = $clog2(DEPTH + 1);
`ifdef STARVE_GUARD_EN
  localparam bit STARVE_ON = 1'b1;
`else
  localparam bit STARVE_ON = 1'b0;
`endif

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_IN*DATA_W-1:0] input_data;
  logic [NUM_IN-1:0]        input_req;
  logic [NUM_IN-1:0]        input_bussy;
  logic [DATA_W-1:0]        output_data;
  logic                     output_req;
  logic                     output_bussy;
  logic [CW-1:0]            prio_count;
  logic [CW-1:0]            reg_count;

  always #5 clk = ~clk;

  ni_class_router #(
    .NUM_IN(NUM_IN), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH),
    .PRIO_HEAD(PRIO), .MAX_STARVE(MAX_STARVE)
  ) dut (
    .clk(clk), .rst(rst), .input_data(input_data), .input_req(input_req),
    .input_bussy(input_bussy), .output_data(output_data), .output_req(output_req),
    .output_bussy(output_bussy), .prio_count(prio_count), .reg_count(reg_count)
  );

  int total = 0;
  int bad   = 0;

  logic [DATA_W-1:0] pq[$];
  logic [DATA_W-1:0] rq[$];
  logic [DATA_W-1:0] exp_q[$];
  int rrp, rrr, starve;
  logic [NUM_IN-1:0] exp_bussy;
  logic              exp_req;
  logic [DATA_W-1:0] exp_data;
  int                exp_pc, exp_rc;
  bit                checking_on = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] hd(input int p);
    return input_data[p*DATA_W + DATA_W - 1 -: 3];
  endfunction

  // Predict this cycle's outputs from the current inputs, then advance to the post-edge state.
  task automatic model_step();
    int  gpi, gri, p;
    bit  force_reg, selp, pop;
    exp_pc = pq.size();
    exp_rc = rq.size();
    if (!rst) begin
      exp_bussy = input_req;
      exp_req   = 1'b0;
      exp_data  = '0;
      pq.delete(); rq.delete();
      rrp = 0; rrr = 0; starve = 0;
      return;
    end
    force_reg = STARVE_ON && (starve >= MAX_STARVE) && (rq.size() > 0);
    selp      = (pq.size() > 0) && !force_reg;
    exp_req   = selp || (rq.size() > 0);
    exp_data  = !exp_req ? '0 : (selp ? pq[0] : rq[0]);
    pop       = exp_req && !output_bussy;
    gpi = -1; gri = -1;
    for (int k = 0; k < NUM_IN; k++) begin
      p = (rrp + k) % NUM_IN;
      if (gpi < 0 && pq.size() < DEPTH && input_req[p] && hd(p) == PRIO) gpi = p;
    end
    for (int k = 0; k < NUM_IN; k++) begin
      p = (rrr + k) % NUM_IN;
      if (gri < 0 && rq.size() < DEPTH && input_req[p] && hd(p) != PRIO) gri = p;
    end
    exp_bussy = input_req;
    if (gpi >= 0) exp_bussy[gpi] = 1'b0;
    if (gri >= 0) exp_bussy[gri] = 1'b0;
    if (STARVE_ON) begin
      if (rq.size() == 0 || (pop && !selp)) starve = 0;
      else if (pop && selp) starve++;
    end
    if (pop) begin
      exp_q.push_back(exp_data);
      if (selp) void'(pq.pop_front());
      else      void'(rq.pop_front());
    end
    if (gpi >= 0) begin
      pq.push_back(input_data[gpi*DATA_W +: DATA_W]);
      rrp = (gpi + 1) % NUM_IN;
    end
    if (gri >= 0) begin
      rq.push_back(input_data[gri*DATA_W +: DATA_W]);
      rrr = (gri + 1) % NUM_IN;
    end
  endtask

  task automatic drive(input int req_pct, input int prio_pct, input int busy_pct, input int rst_pct);
    logic [2:0] h;
    rst = !($urandom_range(0, 99) < rst_pct);
    output_bussy = ($urandom_range(0, 99) < busy_pct);
    for (int i = 0; i < NUM_IN; i++) begin
      input_req[i] = ($urandom_range(0, 99) < req_pct);
      if ($urandom_range(0, 99) < prio_pct) h = PRIO;
      else begin
        h = 3'($urandom_range(0, 7));
        if (h == PRIO) h = 3'b000;
      end
      input_data[i*DATA_W +: DATA_W] = {h, 13'($urandom)};
    end
  endtask

  // Monitor: checks settled outputs just before each rising edge, pops scoreboard on DUT reads.
  always @(negedge clk) begin
    #4;
    if (checking_on) begin
      check("input_bussy", input_bussy, exp_bussy);
      check("output_req",  output_req,  exp_req);
      check("output_data", output_data, exp_data);
      check("prio_count",  prio_count,  exp_pc);
      check("reg_count",   reg_count,   exp_rc);
      if (output_req && !output_bussy) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL pop_unexpected: got %0h expected none at %0t", output_data, $time);
        end else begin
          check("pop_data", output_data, exp_q.pop_front());
        end
      end
    end
  end

  int ph_cyc [6] = '{  4, 200, 200, 250, 200,  60};
  int ph_req [6] = '{ 80,  70,  50,  80,  70,   0};
  int ph_pri [6] = '{ 50,  50,  85,  90,  50,   0};
  int ph_bsy [6] = '{  0,  85,  10,   0,  50,   0};
  int ph_rst [6] = '{100,   0,   0,   0,   3,   0};

  initial begin
    rst = 1'b0; input_req = '0; input_data = '0; output_bussy = 1'b0;
    @(negedge clk);
    model_step();
    for (int ph = 0; ph < 6; ph++) begin
      for (int c = 0; c < ph_cyc[ph]; c++) begin
        @(negedge clk);
        drive(ph_req[ph], ph_pri[ph], ph_bsy[ph], ph_rst[ph]);
        model_step();
        checking_on = 1'b1;
      end
    end
    #6;
    check("scoreboard_empty", exp_q.size(), 0);
    check("drained_prio", prio_count, 0);
    check("drained_reg",  reg_count,  0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
